alu_seq_sat: RTL and testbench

//  Parametrised successor to the single-cycle datapath ALU. Adds a registered,

---
 rtl/alu_seq_sat_if.sv | 34 +++
 rtl/alu_seq_sat.sv | 182 ++++++++++++++++++
 tb/tb_alu_seq_sat.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_sat_if.sv
// alu_seq_sat_if
//   Operation/result handshake bundle for alu_seq_sat.
//   master : issues operations and consumes results (decode/writeback side)
//   slave  : the ALU
//   Signals: in_valid/in_ready/op/src0/src1/shamt/upd_flags (request),
//            out_valid/out_ready/dst/flags (response), busy (MUL in progress).
`timescale 1ns/1ps
interface alu_seq_sat_if #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] src0;
  logic [WIDTH-1:0] src1;
  logic [SHW-1:0]   shamt;
  logic             upd_flags;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] dst;
  logic [2:0]       flags;
  logic             busy;

  modport master (
    output in_valid, op, src0, src1, shamt, upd_flags, out_ready,
    input  in_ready, out_valid, dst, flags, busy
  );

  modport slave (
    input  in_valid, op, src0, src1, shamt, upd_flags, out_ready,
    output in_ready, out_valid, dst, flags, busy
  );
endinterface

// File: rtl/alu_seq_sat.sv
// alu_seq_sat
//   EX-stage ALU with a registered valid/ready result stage, a {V,Z,N} flag
//   register and an iterative signed saturating multiply.
//   Ports:
//     clk  - clock, rising edge
//     rst  - asynchronous active-high reset
//     bus  - alu_seq_sat_if.slave: op/src0/src1/shamt/upd_flags offered with
//            in_valid/in_ready; dst/flags returned with out_valid/out_ready;
//            busy high while a MUL iterates.
//   Ops: 0 ADD, 1 SUB, 2 AND, 3 NOR, 4 SLL, 5 SRL, 6 SRA, 7 LHB, 8 MUL, else NOP.
`timescale 1ns/1ps
module alu_seq_sat #(
  parameter int WIDTH  = 16,
  parameter int SHW    = $clog2(WIDTH),
  parameter bit MUL_EN = 1'b1
) (
  input logic          clk,
  input logic          rst,
  alu_seq_sat_if.slave bus
);
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_NOR = 4'd3;
  localparam logic [3:0] OP_SLL = 4'd4;
  localparam logic [3:0] OP_SRL = 4'd5;
  localparam logic [3:0] OP_SRA = 4'd6;
  localparam logic [3:0] OP_LHB = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;

  localparam logic [WIDTH-1:0] SAT_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [SHW-1:0]   CNT_LAST = SHW'(WIDTH-1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  // {V, value}: a (WIDTH+1)-bit sum overflowed when its top two bits differ.
  function automatic logic [WIDTH:0] sat_sum(input logic signed [WIDTH:0] x);
    if (x[WIDTH] != x[WIDTH-1]) return {1'b1, x[WIDTH] ? SAT_MIN : SAT_MAX};
    return {1'b0, x[WIDTH-1:0]};
  endfunction

  // Magnitude as unsigned; -2^(W-1) maps to 2^(W-1), which still fits.
  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] x);
    return x[WIDTH-1] ? -x : x;
  endfunction

  // {V, value} from a product magnitude and its sign. A negative result may
  // reach 2^(W-1) in magnitude, a positive one only 2^(W-1)-1.
  function automatic logic [WIDTH:0] sat_mul(input logic [2*WIDTH-1:0] m, input logic neg);
    logic [WIDTH-1:0] lo;
    lo = m[WIDTH-1:0];
    if (m == '0) return '0;
    if (!neg) begin
      if (m > {{WIDTH{1'b0}}, SAT_MAX}) return {1'b1, SAT_MAX};
      return {1'b0, lo};
    end
    if (m > {{WIDTH{1'b0}}, SAT_MIN}) return {1'b1, SAT_MIN};
    return {1'b0, -lo};
  endfunction

  state_t                  state;
  logic [SHW-1:0]          cnt_p1;
  logic                    busy_p1;
  logic                    vld_p1;
  logic [WIDTH-1:0]        dst_p1;
  logic [2:0]              flags_p1;
  logic                    upd_mul_p1;
  logic [2*WIDTH-1:0]      ma_p1;
  logic [WIDTH-1:0]        mb_p1;
  logic [2*WIDTH-1:0]      acc_p1;
  logic                    neg_p1;

  logic signed [WIDTH-1:0] a_p0, b_p0;
  logic signed [WIDTH:0]   sum_p0, dif_p0;
  logic [WIDTH:0]          add_sat_p0, sub_sat_p0, mul_sat_p1;
  logic [WIDTH-1:0]        res_p0;
  logic [2:0]              flg_p0;
  logic                    v_p0, zn_wr_p0;
  logic                    in_ready, accept, is_mul;

  assign a_p0       = bus.src0;
  assign b_p0       = bus.src1;
  assign sum_p0     = {a_p0[WIDTH-1], a_p0} + {b_p0[WIDTH-1], b_p0};
  assign dif_p0     = {a_p0[WIDTH-1], a_p0} - {b_p0[WIDTH-1], b_p0};
  assign add_sat_p0 = sat_sum(sum_p0);
  assign sub_sat_p0 = sat_sum(dif_p0);
  assign mul_sat_p1 = sat_mul(acc_p1, neg_p1);

  assign in_ready = (state == S_IDLE) && (!vld_p1 || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign is_mul   = MUL_EN && (bus.op == OP_MUL);

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = vld_p1;
  assign bus.dst       = dst_p1;
  assign bus.flags     = flags_p1;
  assign bus.busy      = busy_p1;

  // ---- stage p0: single-cycle result and candidate flags ----
  always_comb begin
    res_p0   = '0;
    v_p0     = flags_p1[2];
    zn_wr_p0 = 1'b0;
    case (bus.op)
      OP_ADD: begin res_p0 = add_sat_p0[WIDTH-1:0]; v_p0 = add_sat_p0[WIDTH]; zn_wr_p0 = 1'b1; end
      OP_SUB: begin res_p0 = sub_sat_p0[WIDTH-1:0]; v_p0 = sub_sat_p0[WIDTH]; zn_wr_p0 = 1'b1; end
      OP_AND: begin res_p0 = bus.src0 & bus.src1;     zn_wr_p0 = 1'b1; end
      OP_NOR: begin res_p0 = ~(bus.src0 | bus.src1);  zn_wr_p0 = 1'b1; end
      OP_SLL: begin res_p0 = bus.src0 << bus.shamt;   zn_wr_p0 = 1'b1; end
      OP_SRL: begin res_p0 = bus.src0 >> bus.shamt;   zn_wr_p0 = 1'b1; end
      OP_SRA: begin res_p0 = a_p0 >>> bus.shamt;      zn_wr_p0 = 1'b1; end
      OP_LHB: res_p0 = {bus.src1[WIDTH/2-1:0], bus.src0[WIDTH/2-1:0]};
      default: res_p0 = '0;
    endcase
    // LHB and NOP leave every flag alone.
    flg_p0 = zn_wr_p0 ? {v_p0, res_p0 == '0, res_p0[WIDTH-1]} : flags_p1;
  end

  // ---- stage p1: control FSM and registered result ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt_p1     <= '0;
      busy_p1    <= 1'b0;
      vld_p1     <= 1'b0;
      dst_p1     <= '0;
      flags_p1   <= 3'b000;
      upd_mul_p1 <= 1'b0;
    end else begin
      // Consumed result drops unless a new one is loaded below on this edge.
      if (vld_p1 && bus.out_ready) vld_p1 <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (is_mul) begin
              state      <= S_MUL;
              busy_p1    <= 1'b1;
              cnt_p1     <= '0;
              upd_mul_p1 <= bus.upd_flags;
            end else begin
              vld_p1 <= 1'b1;
              dst_p1 <= res_p0;
              if (bus.upd_flags) flags_p1 <= flg_p0;
            end
          end
        end
        S_MUL: begin
          cnt_p1 <= cnt_p1 + SHW'(1);
          if (cnt_p1 == CNT_LAST) begin
            state   <= S_DONE;
            busy_p1 <= 1'b0;
          end
        end
        S_DONE: begin
          if (!vld_p1 || bus.out_ready) begin
            vld_p1 <= 1'b1;
            dst_p1 <= mul_sat_p1[WIDTH-1:0];
            if (upd_mul_p1)
              flags_p1 <= {mul_sat_p1[WIDTH], mul_sat_p1[WIDTH-1:0] == '0, mul_sat_p1[WIDTH-1]};
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // ---- stage p1: multiply datapath, one shift-add per S_MUL cycle ----
  always_ff @(posedge clk) begin
    if (state == S_IDLE && accept && is_mul) begin
      ma_p1  <= {{WIDTH{1'b0}}, mag(a_p0)};
      mb_p1  <= mag(b_p0);
      acc_p1 <= '0;
      neg_p1 <= a_p0[WIDTH-1] ^ b_p0[WIDTH-1];
    end else if (state == S_MUL) begin
      if (mb_p1[0]) acc_p1 <= acc_p1 + ma_p1;
      ma_p1 <= ma_p1 << 1;
      mb_p1 <= mb_p1 >> 1;
    end
  end
endmodule

// File: tb/tb_alu_seq_sat.sv
// tb_alu_seq_sat
//   Scoreboard bench for alu_seq_sat (WIDTH=16). The driver pushes the
//   expected {dst, flags, load edge} of every accepted op; the monitor pops
//   and compares on every result handshake.
`timescale 1ns/1ps
module tb_alu_seq_sat;
  localparam int W  = 16;
  localparam int SW = $clog2(W);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_seq_sat_if #(.WIDTH(W)) bus ();
  alu_seq_sat #(.WIDTH(W), .MUL_EN(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [W-1:0] dst;
    logic [2:0]   flg;
    int           acc_edge;
    int           lat;
  } exp_t;

  exp_t       sb_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  logic [2:0] mflags  = 3'b000;
  bit         rand_ready  = 1'b0;
  bit         fixed_ready = 1'b1;
  bit         rnd_bit     = 1'b1;
  bit         last_acc_ov = 1'b0;

  assign bus.out_ready = rand_ready ? rnd_bit : fixed_ready;

  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge clk); #1;
    rnd_bit = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic with clamping; flags kept in mflags.
  task automatic model(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [SW-1:0] sh, input bit u,
                       output logic [W-1:0] d, output logic [2:0] f);
    longint sa, sb, ua, ub, r, maxv, minv, mask;
    bit v, sat_op, zn_op;
    maxv = (longint'(1) <<< (W-1)) - 1;
    minv = -(longint'(1) <<< (W-1));
    mask = (longint'(1) << W) - 1;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    r = 0; sat_op = 1'b0; zn_op = 1'b0; v = 1'b0;
    case (o)
      4'd0: begin r = sa + sb; sat_op = 1'b1; end
      4'd1: begin r = sa - sb; sat_op = 1'b1; end
      4'd2: begin r = ua & ub; zn_op = 1'b1; end
      4'd3: begin r = ~(ua | ub) & mask; zn_op = 1'b1; end
      4'd4: begin r = (ua << sh) & mask; zn_op = 1'b1; end
      4'd5: begin r = ua >> sh; zn_op = 1'b1; end
      4'd6: begin r = sa >>> sh; zn_op = 1'b1; end
      4'd7: r = longint'({b[W/2-1:0], a[W/2-1:0]});
      4'd8: begin r = sa * sb; sat_op = 1'b1; end
      default: r = 0;
    endcase
    if (sat_op) begin
      if (r > maxv) begin r = maxv; v = 1'b1; end
      else if (r < minv) begin r = minv; v = 1'b1; end
    end
    d = r[W-1:0];
    if (u) begin
      if (sat_op)     mflags = {v, (d == '0), d[W-1]};
      else if (zn_op) mflags = {mflags[2], (d == '0), d[W-1]};
    end
    f = mflags;
  endtask

  // Offer one op, wait for acceptance, push the expectation. Returns just
  // after the accept edge with in_valid low and the inputs scrambled.
  task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [SW-1:0] sh, input bit u, input int lat);
    exp_t e;
    int   n;
    n = 0;
    bus.op = o; bus.src0 = a; bus.src1 = b; bus.shamt = sh; bus.upd_flags = u;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      n_tests++; n_fail++;
      $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, expected 1", bus.in_ready, n);
      bus.in_valid = 1'b0;
      return;
    end
    model(o, a, b, sh, u, e.dst, e.flg);
    e.acc_edge  = cyc + 1;
    e.lat       = lat;
    last_acc_ov = bus.out_valid;
    sb_q.push_back(e);
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.op        = 4'($urandom);
    bus.src0      = W'($urandom);
    bus.src1      = W'($urandom);
    bus.shamt     = SW'($urandom);
    bus.upd_flags = 1'($urandom);
  endtask

  task automatic busy_check();
    int n;
    n = 0;
    @(negedge clk);
    chk("in_ready_during_mul", {31'd0, bus.in_ready}, 32'd0);
    while (bus.busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("busy_cycles", n, 16);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || bus.out_valid) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL drain: %0d results outstanding, expected 0", sb_q.size());
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return 16'h8000;
      1: return 16'h7FFF;
      2: return 16'hFFFF;
      3: return 16'h0000;
      4: return 16'h0001;
      default: return W'($urandom);
    endcase
  endfunction

  // Monitor: compares on every handshake, tracks load edge and hold stability.
  initial begin
    exp_t         e;
    int           first_edge;
    bit           fresh;
    bit           held_ok;
    logic [W-1:0] held_dst;
    fresh = 1'b1; held_ok = 1'b0; first_edge = 0; held_dst = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        fresh = 1'b1; held_ok = 1'b0;
      end else if (bus.out_valid) begin
        if (fresh) begin
          first_edge = cyc; fresh = 1'b0; held_ok = 1'b0;
        end else if (held_ok) begin
          chk("hold_dst", {16'd0, bus.dst}, {16'd0, held_dst});
        end
        if (bus.out_ready) begin
          if (sb_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_result: dst=%0h with no expectation pending", bus.dst);
          end else begin
            e = sb_q.pop_front();
            chk("dst",   {16'd0, bus.dst},   {16'd0, e.dst});
            chk("flags", {29'd0, bus.flags}, {29'd0, e.flg});
            if (e.lat >= 0) chk("latency", first_edge - e.acc_edge, e.lat);
          end
          fresh = 1'b1; held_ok = 1'b0;
        end else begin
          held_dst = bus.dst; held_ok = 1'b1;
        end
      end
    end
  end

  initial begin
    exp_t            e;
    logic [3:0]      o;
    logic [W-1:0]    a, b;
    logic [SW-1:0]   sh;
    bit              u;
    bus.in_valid = 1'b0; bus.op = '0; bus.src0 = '0; bus.src1 = '0;
    bus.shamt = '0; bus.upd_flags = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_dst",       {16'd0, bus.dst},       32'd0);
    chk("rst_flags",     {29'd0, bus.flags},     32'd0);
    chk("rst_busy",      {31'd0, bus.busy},      32'd0);
    chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    @(posedge clk); #1;

    // Directed, consumer always ready.
    issue(4'd0, 16'h7000, 16'h1000, 4'd0, 1'b1, 0);
    issue(4'd1, 16'h8000, 16'h0001, 4'd0, 1'b1, 0);
    issue(4'd2, 16'h0000, 16'hFFFF, 4'd0, 1'b1, 0);
    issue(4'd1, 16'h0000, 16'h8000, 4'd0, 1'b1, 0);
    issue(4'd1, 16'hFFFF, 16'h8000, 4'd0, 1'b1, 0);
    issue(4'd6, 16'h8000, 16'h0000, 4'd15, 1'b1, 0);
    issue(4'd6, 16'h4000, 16'h0000, 4'd14, 1'b1, 0);
    issue(4'd7, 16'h12AB, 16'h00CD, 4'd0, 1'b1, 0);
    issue(4'd15, 16'h1234, 16'h5678, 4'd0, 1'b1, 0);
    issue(4'd4, 16'h0001, 16'h0000, 4'd15, 1'b1, 0);
    issue(4'd5, 16'h8000, 16'h0000, 4'd15, 1'b1, 0);
    issue(4'd3, 16'h0000, 16'h0000, 4'd0, 1'b0, 0);
    issue(4'd8, 16'hFFFD, 16'h0005, 4'd0, 1'b1, 17);
    busy_check();
    issue(4'd8, 16'h0100, 16'h0100, 4'd0, 1'b1, 17);
    issue(4'd8, 16'h8000, 16'hFFFF, 4'd0, 1'b1, 17);
    issue(4'd8, 16'h8000, 16'h0001, 4'd0, 1'b1, 17);
    issue(4'd8, 16'h0000, 16'hFFFF, 4'd0, 1'b1, 17);
    drain();

    // Backpressure: result held three cycles, then a back-to-back accept.
    fixed_ready = 1'b0;
    issue(4'd0, 16'h0001, 16'h0002, 4'd0, 1'b0, 0);
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready",  {31'd0, bus.in_ready},  32'd0);
      chk("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
    end
    @(posedge clk); #1;
    fixed_ready = 1'b1;
    issue(4'd1, 16'h0005, 16'h0003, 4'd0, 1'b1, 0);
    chk("b2b_result_pending", {31'd0, last_acc_ov}, 32'd1);
    drain();

    // Reset in the middle of a multiply.
    issue(4'd8, 16'h0003, 16'h0004, 4'd0, 1'b1, 17);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    e = sb_q.pop_back();
    mflags = 3'b000;
    #1;
    chk("midmul_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("midmul_flags",     {29'd0, bus.flags},     32'd0);
    chk("midmul_busy",      {31'd0, bus.busy},      32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    issue(4'd8, 16'h0003, 16'hFFFC, 4'd0, 1'b1, 17);
    drain();

    // Randomized ops against the reference model with a random consumer.
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      o  = 4'($urandom_range(0, 15));
      a  = pick();
      b  = pick();
      sh = SW'($urandom);
      u  = 1'($urandom);
      issue(o, a, b, sh, u, (o == 4'd8) ? -1 : 0);
    end
    rand_ready  = 1'b0;
    fixed_ready = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
